// File: rtl/onegen.sv
// onegen: emits, in strictly increasing numeric order, every 16-bit word that
// has exactly `count` bits set, over a valid/ready handshake.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       begin a run (sampled only when idle)
//   count       number of ones per word (0..16), sampled with start
//   busy        high while a run is in progress
//   data_valid  data holds a word to be transferred
//   data_ready  consumer accepts data this cycle
//   data        generated word
//   last        data is the final word of the run
//   done        one-cycle pulse after the final word is transferred
//   err         one-cycle pulse when start carries count > 16
module onegen #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       count,
  output logic             busy,
  output logic             data_valid,
  input  logic             data_ready,
  output logic [WIDTH-1:0] data,
  output logic             last,
  output logic             done,
  output logic             err
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH:0]   ONE_WIDE = (WIDTH + 1)'(1);
  localparam logic [4:0]       MAX_CNT  = 5'(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] fin_q, fin_d;   // final word of the current run
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [WIDTH:0]   mask_wide;
  logic [WIDTH-1:0] first_word;
  logic [WIDTH-1:0] final_word;
  logic [WIDTH-1:0] succ;
  logic [WIDTH-1:0] g_t, g_t1, g_low;
  logic [4:0]       g_shift;
  logic             xfer;

  // Index of the lowest set bit; WIDTH when the word is zero.
  function automatic logic [4:0] ctz(input logic [WIDTH-1:0] v);
    ctz = 5'(WIDTH);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) ctz = 5'(i);
    end
  endfunction

  // Lowest word with `count` ones, computed one bit wider so count = 16 works.
  assign mask_wide  = (ONE_WIDE << count) - ONE_WIDE;
  assign first_word = mask_wide[WIDTH-1:0];
  // Same ones packed at the top; a shift of 16 for count = 0 yields zero.
  assign final_word = first_word << (MAX_CNT - count);

  // Gosper's hack: next larger word with the same popcount. Only used while
  // the current word is not final, so the wrap at the top is never observed.
  always_comb begin
    g_t     = data_q | (data_q - ONE);
    g_t1    = g_t + ONE;
    g_low   = (~g_t & g_t1) - ONE;
    g_shift = ctz(data_q) + 5'd1;
    succ    = g_t1 | (g_low >> g_shift);
  end

  assign busy       = (state_q == RUN);
  assign data_valid = (state_q == RUN);
  assign last       = (state_q == RUN) && (data_q == fin_q);
  assign data       = data_q;
  assign done       = done_q;
  assign err        = err_q;
  assign xfer       = data_valid && data_ready;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no latch can be inferred.
    state_d = state_q;
    data_d  = data_q;
    fin_d   = fin_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (count > MAX_CNT) begin
            err_d = 1'b1;
          end else begin
            state_d = RUN;
            data_d  = first_word;
            fin_d   = final_word;
          end
        end
      end
      RUN: begin
        // start and count are deliberately not looked at here.
        if (xfer) begin
          if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            data_d = succ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset clears every register, including data and the final-word
    // latch, so outputs are fully defined the cycle after rst.
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      fin_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same
      // pre-edge values.
      state_q <= state_d;
      data_q  <= data_d;
      fin_q   <= fin_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_onegen.sv
module tb_onegen;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  count;
  logic        busy;
  logic        data_valid;
  logic        data_ready;
  logic [15:0] data;
  logic        last;
  logic        done;
  logic        err;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   total_xfers = 0;

  // monitor state
  bit          exp_err  = 1'b0;
  bit          exp_done = 1'b0;
  bit          rst_chk  = 1'b0;
  bit          stall_prev = 1'b0;
  logic [15:0] prev_data;
  logic        prev_last;

  onegen #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .count(count), .busy(busy),
    .data_valid(data_valid), .data_ready(data_ready), .data(data),
    .last(last), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: scan all 16-bit values in order, keep those with the
  // required popcount; the largest one carries last.
  task automatic push_run(input int c, output int n);
    exp_t e;
    n = 0;
    for (int v = 0; v < 65536; v++) begin
      if ($countones(16'(v)) == c) begin
        e.data = 16'(v);
        e.last = 1'b0;
        sb.push_back(e);
        n++;
      end
    end
    e = sb.pop_back();
    e.last = 1'b1;
    sb.push_back(e);
  endtask

  // Monitor: samples on the falling edge, between driver updates and DUT edges.
  always @(negedge clk) begin
    exp_t e;
    if (rst_chk) begin
      check(busy == 1'b0, "rst_busy", 32'(busy), 0);
      check(data_valid == 1'b0, "rst_valid", 32'(data_valid), 0);
      check(last == 1'b0, "rst_last", 32'(last), 0);
      check(done == 1'b0, "rst_done", 32'(done), 0);
      check(err == 1'b0, "rst_err", 32'(err), 0);
      check(data == 16'h0000, "rst_data", 32'(data), 0);
    end else begin
      check(err == exp_err, "err_pulse", 32'(err), 32'(exp_err));
      check(done == exp_done, "done_pulse", 32'(done), 32'(exp_done));
      check(busy == data_valid, "busy_eq_valid", 32'(busy), 32'(data_valid));
      if (!data_valid) check(last == 1'b0, "last_idle", 32'(last), 0);
      if (stall_prev)
        check(data_valid && data == prev_data && last == prev_last, "stall_hold",
              {15'd0, data_valid, data}, {16'd1, prev_data});
    end

    exp_done   = 1'b0;
    stall_prev = 1'b0;
    if (rst) begin
      rst_chk = 1'b1;
      exp_err = 1'b0;
    end else begin
      rst_chk = 1'b0;
      exp_err = start && !busy && (count > 5'd16);
      if (data_valid) begin
        check(sb.size() != 0, "word_expected", 32'(sb.size()), 1);
        if (sb.size() != 0 && data_ready) begin
          e = sb.pop_front();
          check(data == e.data, "word_data", 32'(data), 32'(e.data));
          check(last == e.last, "word_last", 32'(last), 32'(e.last));
          exp_done = e.last;
          total_xfers++;
        end else if (!data_ready) begin
          stall_prev = 1'b1;
          prev_data  = data;
          prev_last  = last;
        end
      end
    end
  end

  task automatic run(input logic [4:0] c, input bit rnd_ready, input bit midrun);
    int n;
    int cyc;
    int limit;
    push_run(int'(c), n);
    limit      = n * 8 + 20;
    start      = 1'b1;
    count      = c;
    data_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    cyc        = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (done || cyc >= limit) break;
      start = midrun ? 1'($urandom_range(0, 1)) : 1'b0;
      count = midrun ? 5'($urandom) : c;
      if (rnd_ready) data_ready = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    count = c;
    data_ready = 1'b1;
    check(done == 1'b1, "run_done_seen", 32'(done), 1);
    if (!rnd_ready) check(cyc == n + 1, "run_cycles", 32'(cyc), 32'(n + 1));
    check(sb.size() == 0, "run_drained", 32'(sb.size()), 0);
  endtask

  task automatic bad(input logic [4:0] c);
    start = 1'b1;
    count = c;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check(sb.size() == 0, "bad_no_words", 32'(sb.size()), 0);
  endtask

  task automatic reset_mid_run();
    int n;
    int base;
    int cyc;
    push_run(4, n);
    base  = total_xfers;
    start = 1'b1;
    count = 5'd4;
    data_ready = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end while (total_xfers != base + 10 && cyc < 50);
    check(total_xfers == base + 10, "rst_reach_10", 32'(total_xfers - base), 10);
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check(busy == 1'b0, "rst_abort_idle", 32'(busy), 0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    count      = 5'd0;
    data_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    run(5'd1, 1'b0, 1'b0);   // 0x0001 .. 0x8000
    run(5'd0, 1'b0, 1'b0);   // back-to-back, single 0x0000
    run(5'd16, 1'b0, 1'b0);  // single 0xFFFF
    bad(5'd17);
    bad(5'd31);
    run(5'd2, 1'b1, 1'b0);   // 120 words with random stalls
    run(5'd8, 1'b0, 1'b1);   // 12870 words, start noise mid-run
    reset_mid_run();
    run(5'd3, 1'b1, 1'b0);   // first word 0x0007 after the abort
    run(5'd15, 1'b1, 1'b1);

    repeat (2) @(posedge clk);
    check(sb.size() == 0, "final_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
